// File: rtl/wb_pkg.sv
// Shared types and bus widths for the Wishbone command initiator.
package wb_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/wb_cmd_master.sv
// Wishbone classic (B4) single-beat initiator. It takes one command on a valid/ready port
// and returns one response, which carries either the read data or a timeout error.
module wb_cmd_master
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [WB_ADR_W-1:0] cmd_adr_i,
  input  logic [WB_DAT_W-1:0] cmd_dat_i,
  input  logic [WB_SEL_W-1:0] cmd_sel_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [WB_DAT_W-1:0] rsp_dat_o,
  output logic                rsp_err_o,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [WB_SEL_W-1:0] wbm_sel_o,
  output logic [WB_ADR_W-1:0] wbm_adr_o,
  output logic [WB_DAT_W-1:0] wbm_dat_o,
  input  logic                wbm_ack_i,
  input  logic [WB_DAT_W-1:0] wbm_dat_i,
  output logic                busy_o
);

  state_t              r_state;
  logic [TO_W-1:0]     r_cnt;
  logic                r_cyc;
  logic                r_we;
  logic [WB_SEL_W-1:0] r_sel;
  logic [WB_ADR_W-1:0] r_adr;
  logic [WB_DAT_W-1:0] r_dat;
  logic                r_rsp_valid;
  logic                r_rsp_err;
  logic [WB_DAT_W-1:0] r_rsp_dat;

  logic [TO_W-1:0]     w_cnt_nxt;
  logic                w_timeout;

  // The counter holds the number of BUS cycles already completed. The abort fires on the
  // edge that closes cycle number TIMEOUT_CYCLES.
  assign w_cnt_nxt = r_cnt + TO_W'(1);
  assign w_timeout = (w_cnt_nxt == TO_W'(TIMEOUT_CYCLES));

  // These outputs are decoded only from the state or come straight from flops, so there is
  // no combinational path from any input to any output.
  assign cmd_ready_o = (r_state == IDLE);
  assign busy_o      = (r_state != IDLE);
  assign wbm_cyc_o   = r_cyc;
  assign wbm_stb_o   = r_cyc;
  assign wbm_we_o    = r_we;
  assign wbm_sel_o   = r_sel;
  assign wbm_adr_o   = r_adr;
  assign wbm_dat_o   = r_dat;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_err_o   = r_rsp_err;
  assign rsp_dat_o   = r_rsp_dat;

  // NOTE: all state updates use non-blocking assignments, so every branch reads the values
  // from before the edge. The async reset clears cyc/stb at once, even in the middle of a cycle.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_dat   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid_i) begin
            r_we    <= cmd_we_i;
            r_adr   <= cmd_adr_i;
            r_dat   <= cmd_dat_i;
            r_sel   <= cmd_sel_i;
            r_cyc   <= 1'b1;
            r_cnt   <= '0;
            r_state <= BUS;
          end
        end

        BUS: begin
          r_cnt <= w_cnt_nxt;
          // If ack and timeout fall on the same edge, ack is checked first and wins.
          if (wbm_ack_i) begin
            r_cyc       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_dat   <= r_we ? '0 : wbm_dat_i;
            r_state     <= RESP;
          end else if (w_timeout) begin
            r_cyc       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_dat   <= '0;
            r_state     <= RESP;
          end
        end

        RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_dat   <= '0;
            r_state     <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master. It uses directed and random transactions, an
// emulated Wishbone responder and a transaction-level model of the expected response.
module tb_wb_cmd_master;

  localparam int T = 4;

  logic        wb_clk_i;
  logic        wb_rst_n_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [31:0] cmd_adr_i;
  logic [31:0] cmd_dat_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;
  logic        busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  wb_cmd_master #(.TIMEOUT_CYCLES(T), .TO_W(8)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_n_i  (wb_rst_n_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_we_i    (cmd_we_i),
    .cmd_adr_i   (cmd_adr_i),
    .cmd_dat_i   (cmd_dat_i),
    .cmd_sel_i   (cmd_sel_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_dat_o   (rsp_dat_o),
    .rsp_err_o   (rsp_err_o),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_ack_i   (wbm_ack_i),
    .wbm_dat_i   (wbm_dat_i),
    .busy_o      (busy_o)
  );

  initial begin
    wb_clk_i = 1'b0;
    forever #5 wb_clk_i = ~wb_clk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: got %0h required %0h", tag, obs, exp);
    end
  endtask

  // Step to just after the next rising edge. All sampling and driving happens here.
  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  // Runs one command through the DUT. ack_at gives the BUS cycle (1-based) in which the
  // responder acks; 0 means it never acks. rsp_wait is the number of back-pressure cycles.
  task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int ack_at, input logic [31:0] rdata,
                        input int rsp_wait);
    int          n;
    logic        exp_err;
    int          exp_n;
    logic [31:0] exp_dat;
    exp_err = !(ack_at >= 1 && ack_at <= T);
    exp_n   = exp_err ? T : ack_at;
    exp_dat = (exp_err || we) ? 32'h0 : rdata;

    check("ready_in_idle", 32'(cmd_ready_o), 32'd1);
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_dat_i   = dat;
    cmd_sel_i   = sel;
    tick();
    cmd_valid_i = 1'b0;
    cmd_adr_i   = $urandom;
    cmd_dat_i   = $urandom;

    n = 0;
    while (wbm_cyc_o === 1'b1 && n < T + 4) begin
      n++;
      check("stb_with_cyc", 32'(wbm_stb_o), 32'd1);
      check("bus_we", 32'(wbm_we_o), 32'(we));
      check("bus_adr", wbm_adr_o, adr);
      check("bus_dat", wbm_dat_o, dat);
      check("bus_sel", 32'(wbm_sel_o), 32'(sel));
      check("no_rsp_in_bus", 32'(rsp_valid_o), 32'd0);
      check("not_ready_in_bus", 32'(cmd_ready_o), 32'd0);
      wbm_ack_i = (n == ack_at);
      wbm_dat_i = (n == ack_at) ? rdata : $urandom;
      tick();
    end
    wbm_ack_i = 1'b0;

    check("bus_cycles", 32'(n), 32'(exp_n));
    check("stb_dropped", 32'(wbm_stb_o), 32'd0);
    check("rsp_valid", 32'(rsp_valid_o), 32'd1);
    check("rsp_err", 32'(rsp_err_o), 32'(exp_err));
    check("rsp_dat", rsp_dat_o, exp_dat);
    check("busy_in_resp", 32'(busy_o), 32'd1);

    // Offer a second command while the response is pending. It must not be taken.
    cmd_valid_i = 1'b1;
    for (int i = 0; i < rsp_wait; i++) begin
      tick();
      check("held_valid", 32'(rsp_valid_o), 32'd1);
      check("held_err", 32'(rsp_err_o), 32'(exp_err));
      check("held_dat", rsp_dat_o, exp_dat);
      check("not_ready_in_resp", 32'(cmd_ready_o), 32'd0);
      check("no_cyc_in_resp", 32'(wbm_cyc_o), 32'd0);
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    check("rsp_cleared", 32'(rsp_valid_o), 32'd0);
    check("err_cleared", 32'(rsp_err_o), 32'd0);
    check("no_accept_at_handshake", 32'(wbm_cyc_o), 32'd0);
    check("ready_after_rsp", 32'(cmd_ready_o), 32'd1);
    cmd_valid_i = 1'b0;
  endtask

  initial begin
    wb_rst_n_i  = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_we_i    = 1'b0;
    cmd_adr_i   = '0;
    cmd_dat_i   = '0;
    cmd_sel_i   = '0;
    rsp_ready_i = 1'b0;
    wbm_ack_i   = 1'b0;
    wbm_dat_i   = '0;

    // Values held during reset.
    tick();
    tick();
    check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_rsp_err", 32'(rsp_err_o), 32'd0);
    check("rst_rsp_dat", rsp_dat_o, 32'd0);
    check("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    check("rst_stb", 32'(wbm_stb_o), 32'd0);
    check("rst_we", 32'(wbm_we_o), 32'd0);
    check("rst_adr", wbm_adr_o, 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    wb_rst_n_i = 1'b1;
    tick();

    // Write that is acked in the second BUS cycle.
    do_txn(1'b1, 32'h3000_0004, 32'hCAFE_F00D, 4'hF, 2, 32'hDEAD_BEEF, 0);
    // Read that is acked in the first BUS cycle.
    do_txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, 1, 32'h1234_5678, 0);
    // Timeout with no ack, followed by a normal read.
    do_txn(1'b0, 32'h3000_000C, 32'h0, 4'h3, 0, 32'h0, 0);
    do_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 3, 32'hA5A5_5A5A, 0);
    // Back-pressure for five cycles.
    do_txn(1'b0, 32'h3000_0014, 32'h0, 4'h1, 2, 32'h0BAD_F00D, 5);

    // A stray ack in IDLE must be ignored.
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h7777_7777;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stray_ack_no_rsp", 32'(rsp_valid_o), 32'd0);
      check("stray_ack_idle", 32'(busy_o), 32'd0);
      check("stray_ack_no_cyc", 32'(wbm_cyc_o), 32'd0);
    end
    wbm_ack_i = 1'b0;
    // The ack lands on the same edge as the timeout, and the ack wins.
    do_txn(1'b0, 32'h3000_0018, 32'h0, 4'hC, T, 32'h600D_DA7A, 1);

    // Random transactions. ack_at covers early, boundary, late (timeout) and no-ack cases.
    for (int k = 0; k < 24; k++) begin
      do_txn(1'($urandom), $urandom, $urandom, 4'($urandom), int'($urandom_range(0, T + 2)),
             $urandom, int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a bus cycle.
    cmd_valid_i = 1'b1;
    cmd_we_i    = 1'b0;
    cmd_adr_i   = 32'h3000_0020;
    cmd_sel_i   = 4'hF;
    tick();
    cmd_valid_i = 1'b0;
    tick();
    check("pre_rst_cyc", 32'(wbm_cyc_o), 32'd1);
    wb_rst_n_i = 1'b0;
    #1;
    check("async_rst_cyc", 32'(wbm_cyc_o), 32'd0);
    check("async_rst_stb", 32'(wbm_stb_o), 32'd0);
    check("async_rst_rsp", 32'(rsp_valid_o), 32'd0);
    tick();
    wb_rst_n_i = 1'b1;
    tick();
    check("post_rst_ready", 32'(cmd_ready_o), 32'd1);
    check("post_rst_rsp", 32'(rsp_valid_o), 32'd0);
    check("post_rst_cyc", 32'(wbm_cyc_o), 32'd0);
    do_txn(1'b1, 32'h3000_0024, 32'h0102_0304, 4'h6, 1, 32'h0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
